// File: rtl/pass_entry_tx.sv
// Code entry front end: debounces the enter button, collects DIGITS switch values into a packed
// code, then offers it to a downstream checker with a VALID/READY handshake.
module pass_entry_tx #(
  parameter int unsigned DIGITS     = 3,
  parameter int unsigned DIG_W      = 3,
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [DIG_W-1:0]        D,
  input  logic                    EN,
  input  logic                    CLR,
  input  logic                    READY,
  output logic [DIGITS*DIG_W-1:0] CODE,
  output logic                    VALID,
  output logic [DIGITS-1:0]       LEDS,
  output logic                    BUSY
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StSend} state_e;

  logic [CNT_W-1:0]        deb_cnt_q;
  logic                    en_db_q;
  logic                    en_db_prev_q;
  logic                    press;

  state_e                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [DIGITS*DIG_W-1:0] code_q;
  logic [DIGITS-1:0]       leds_q;
  logic                    valid_q;
  logic                    busy_q;

  // Count consecutive samples that disagree with the accepted level; any agreeing sample restarts.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      deb_cnt_q    <= '0;
      en_db_q      <= 1'b0;
      en_db_prev_q <= 1'b0;
    end else begin
      en_db_prev_q <= en_db_q;
      if (EN != en_db_q) begin
        if (deb_cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
          en_db_q   <= EN;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + CNT_W'(1);
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  assign press = en_db_q & ~en_db_prev_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      idx_q   <= '0;
      code_q  <= '0;
      leds_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StCollect: begin
          // CLR wins over a simultaneous press; in IDLE there is nothing to abandon.
          if (state_q == StCollect && CLR) begin
            state_q <= StIdle;
            idx_q   <= '0;
            code_q  <= '0;
            leds_q  <= '0;
            busy_q  <= 1'b0;
          end else if (press) begin
            code_q[(DIGITS - 1 - 32'(idx_q)) * DIG_W +: DIG_W] <= D;
            leds_q[idx_q] <= 1'b1;
            busy_q        <= 1'b1;
            if (idx_q == LastIdx) begin
              state_q <= StSend;
              valid_q <= 1'b1;
            end else begin
              state_q <= StCollect;
              idx_q   <= idx_q + IDX_W'(1);
            end
          end
        end
        StSend: begin
          if (READY) begin
            state_q <= StIdle;
            idx_q   <= '0;
            code_q  <= '0;
            leds_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          idx_q   <= '0;
          code_q  <= '0;
          leds_q  <= '0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign CODE  = code_q;
  assign VALID = valid_q;
  assign LEDS  = leds_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_pass_entry_tx.sv
// Directed and randomized bench for pass_entry_tx against a queue-based reference model.
module tb_pass_entry_tx;

  localparam int unsigned DIGITS = 3;
  localparam int unsigned DIG_W  = 3;
  localparam int unsigned DEB    = 4;

  logic                    CLK = 1'b0;
  logic                    RST_N = 1'b0;
  logic [DIG_W-1:0]        D = '0;
  logic                    EN = 1'b0;
  logic                    CLR = 1'b0;
  logic                    READY = 1'b0;
  logic [DIGITS*DIG_W-1:0] CODE;
  logic                    VALID;
  logic [DIGITS-1:0]       LEDS;
  logic                    BUSY;

  int errs = 0;
  int checks = 0;

  pass_entry_tx #(.DIGITS(DIGITS), .DIG_W(DIG_W), .DEB_CYCLES(DEB)) dut (
    .CLK(CLK), .RST_N(RST_N), .D(D), .EN(EN), .CLR(CLR), .READY(READY),
    .CODE(CODE), .VALID(VALID), .LEDS(LEDS), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Reference model: debounced level flips when the last DEB samples all disagree with it;
  // captured digits live in a queue, SEND is simply "queue full and offered".
  bit          hist[$];
  bit          m_db = 0;
  bit          m_db_prev = 0;
  int unsigned m_dig[$];
  bit          m_send = 0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hist.delete();
      m_dig.delete();
      m_db = 0;
      m_db_prev = 0;
      m_send = 0;
    end else begin
      bit press;
      bit flip;
      press = m_db & ~m_db_prev;
      if (m_send) begin
        if (READY) begin
          m_dig.delete();
          m_send = 0;
        end
      end else if (m_dig.size() > 0 && CLR) begin
        m_dig.delete();
      end else if (press) begin
        m_dig.push_back(int'(D));
        if (m_dig.size() == DIGITS) m_send = 1;
      end
      m_db_prev = m_db;
      hist.push_back(EN);
      if (hist.size() > DEB) hist.pop_front();
      flip = (hist.size() == DEB);
      foreach (hist[i]) if (hist[i] == m_db) flip = 0;
      if (flip) m_db = ~m_db;
    end
  end

  function automatic int exp_code();
    int c = 0;
    foreach (m_dig[i]) c |= m_dig[i] << ((DIGITS - 1 - i) * DIG_W);
    return c;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("cyc_code", int'(CODE), exp_code());
    chk("cyc_valid", int'(VALID), int'(m_send));
    chk("cyc_leds", int'(LEDS), (1 << m_dig.size()) - 1);
    chk("cyc_busy", int'(BUSY), int'(m_dig.size() > 0));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input int d);
    D = DIG_W'(d);
    EN = 1'b1;
    cyc(DEB + 2);
    EN = 1'b0;
    cyc(DEB + 2);
  endtask

  task automatic all_zero(input string name);
    chk({name, "_code"}, int'(CODE), 0);
    chk({name, "_valid"}, int'(VALID), 0);
    chk({name, "_leds"}, int'(LEDS), 0);
    chk({name, "_busy"}, int'(BUSY), 0);
  endtask

  task automatic handshake();
    READY = 1'b1;
    cyc(1);
    READY = 1'b0;
  endtask

  initial begin
    #1 all_zero("reset");
    cyc(2);
    RST_N = 1'b1;
    cyc(2);

    // Short glitch must not register.
    EN = 1'b1;
    cyc(3);
    EN = 1'b0;
    cyc(10);
    chk("glitch_leds", int'(LEDS), 0);

    // 5,2,7 with READY low, then handshake.
    press(5); chk("e1_leds", int'(LEDS), 3'b001);
    press(2); chk("e2_leds", int'(LEDS), 3'b011);
    press(7); chk("e3_leds", int'(LEDS), 3'b111);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", int'(VALID), 1);
      chk("hold_code", int'(CODE), 9'h157);
      cyc(1);
    end
    handshake();
    all_zero("after_hs");

    // Abandon then re-enter.
    press(3); press(4);
    CLR = 1'b1; cyc(1); CLR = 1'b0;
    chk("clr_leds", int'(LEDS), 0);
    chk("clr_busy", int'(BUSY), 0);
    press(1); press(1); press(1);
    chk("111_code", int'(CODE), 9'h049);
    chk("111_valid", int'(VALID), 1);

    // Press and CLR while offering are ignored.
    CLR = 1'b1; press(6); CLR = 1'b0;
    chk("send_code", int'(CODE), 9'h049);
    chk("send_valid", int'(VALID), 1);
    handshake();

    // Long hold yields one capture.
    press(1);
    D = 3'd7; EN = 1'b1; cyc(20); EN = 1'b0; cyc(DEB + 2);
    chk("hold20_leds", int'(LEDS), 3'b011);
    chk("hold20_code", int'(CODE), 9'h078);
    CLR = 1'b1; cyc(1); CLR = 1'b0;

    // Reset mid-debounce after one digit; EN still high afterwards.
    press(4);
    D = 3'd2; EN = 1'b1; cyc(2);
    #2 RST_N = 1'b0;
    #1 all_zero("rst_mid");
    cyc(1);
    #2 RST_N = 1'b1;
    cyc(8); EN = 1'b0; cyc(DEB + 2);
    chk("rst_en_leds", int'(LEDS), 3'b001);
    chk("rst_en_code", int'(CODE), 9'h080);
    press(3); press(4);
    chk("pre_rst_valid", int'(VALID), 1);
    #2 RST_N = 1'b0;
    #1 all_zero("rst_send");
    cyc(1);
    #2 RST_N = 1'b1;
    cyc(1);
    press(5);
    chk("slot0_code", int'(CODE), 9'h140);
    chk("slot0_leds", int'(LEDS), 3'b001);

    // CLR in the exact press cycle.
    D = 3'd6; EN = 1'b1;
    cyc(DEB);
    CLR = 1'b1; cyc(1); CLR = 1'b0;
    EN = 1'b0; cyc(DEB + 2);
    chk("clrpress_leds", int'(LEDS), 0);
    chk("clrpress_busy", int'(BUSY), 0);

    // Random phase.
    for (int s = 0; s < 400; s++) begin
      int len;
      EN = 1'($urandom_range(0, 1));
      D = DIG_W'($urandom);
      len = $urandom_range(1, 10);
      for (int k = 0; k < len; k++) begin
        CLR = ($urandom_range(0, 15) == 0);
        READY = ($urandom_range(0, 3) == 0);
        cyc(1);
      end
    end
    CLR = 1'b0; READY = 1'b0; EN = 1'b0;
    cyc(DEB + 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
